// File: rtl/pb_rst_debounce.sv
// pb_rst_debounce
//   Debounces an asynchronous, active-low push-button and reports press,
//   release and long-press events. The cleaned level is meant to drive the
//   RST_n input of a downstream reset synchronizer.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable synchronized samples needed to accept
//                     a level change (2 .. 2^24)
//   HOLD_CYCLES     : debounced-press duration that flags a long press
//                     (must exceed DEBOUNCE_CYCLES)
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   pb_raw_n   : raw bouncy button level, 0 = pressed (asynchronous)
//   pb_clean_n : registered debounced level, 0 = pressed
//   pb_press   : one-cycle pulse on each accepted press
//   pb_release : one-cycle pulse on each accepted release
//   pb_hold    : one-cycle pulse when a press has lasted HOLD_CYCLES
module pb_rst_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_raw_n,
  output logic pb_clean_n,
  output logic pb_press,
  output logic pb_release,
  output logic pb_hold
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    REL   = 2'd0,
    CHK_P = 2'd1,
    PRS   = 2'd2,
    CHK_R = 2'd3
  } state_t;

  state_t          state_reg;
  logic [1:0]      sync_reg;
  logic [DW-1:0]   db_cnt_reg;
  logic [HW-1:0]   hold_cnt_reg;
  logic            clean_n_reg;
  logic            press_reg;
  logic            release_reg;
  logic            hold_reg;

  logic            sync_n;
  logic            release_accept;

  assign sync_n = sync_reg[1];

  // A release accepted on the same edge the hold count would complete ends
  // the press, so the long-press pulse is suppressed to keep pulses exclusive.
  assign release_accept = (state_reg == CHK_R) && sync_n && (db_cnt_reg == DB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg     <= 2'b11;
      state_reg    <= REL;
      db_cnt_reg   <= '0;
      hold_cnt_reg <= '0;
      clean_n_reg  <= 1'b1;
      press_reg    <= 1'b0;
      release_reg  <= 1'b0;
      hold_reg     <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], pb_raw_n};
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      hold_reg    <= 1'b0;

      // Hold timing follows the debounced level, so release bounces that
      // fall back into PRS neither pause nor restart it.
      if (!clean_n_reg && (hold_cnt_reg != HOLD_MAX)) begin
        hold_cnt_reg <= hold_cnt_reg + 1'b1;
        if ((hold_cnt_reg == HOLD_PRE) && !release_accept) begin
          hold_reg <= 1'b1;
        end
      end

      unique case (state_reg)
        REL: begin
          if (!sync_n) begin
            state_reg  <= CHK_P;
            db_cnt_reg <= DW'(1);
          end else begin
            db_cnt_reg <= '0;
          end
        end
        CHK_P: begin
          if (!sync_n) begin
            if (db_cnt_reg == DB_LAST) begin
              state_reg    <= PRS;
              clean_n_reg  <= 1'b0;
              press_reg    <= 1'b1;
              db_cnt_reg   <= '0;
              hold_cnt_reg <= '0;
            end else begin
              db_cnt_reg <= db_cnt_reg + 1'b1;
            end
          end else begin
            state_reg  <= REL;
            db_cnt_reg <= '0;
          end
        end
        PRS: begin
          if (sync_n) begin
            state_reg  <= CHK_R;
            db_cnt_reg <= DW'(1);
          end else begin
            db_cnt_reg <= '0;
          end
        end
        CHK_R: begin
          if (sync_n) begin
            if (db_cnt_reg == DB_LAST) begin
              state_reg   <= REL;
              clean_n_reg <= 1'b1;
              release_reg <= 1'b1;
              db_cnt_reg  <= '0;
            end else begin
              db_cnt_reg <= db_cnt_reg + 1'b1;
            end
          end else begin
            state_reg  <= PRS;
            db_cnt_reg <= '0;
          end
        end
        default: begin
          state_reg  <= REL;
          db_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign pb_clean_n = clean_n_reg;
  assign pb_press   = press_reg;
  assign pb_release = release_reg;
  assign pb_hold    = hold_reg;

endmodule

// File: tb/tb_pb_rst_debounce.sv
// Testbench for pb_rst_debounce with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
// A behavioural model (run-length of disagreeing samples, event times by
// cycle number) predicts every output each cycle; scenario tasks add
// targeted timing checks.
module tb_pb_rst_debounce;

  localparam int D = 4;
  localparam int H = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pb_raw_n = 1'b1;
  logic pb_clean_n, pb_press, pb_release, pb_hold;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pb_rst_debounce #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pb_raw_n  (pb_raw_n),
    .pb_clean_n(pb_clean_n),
    .pb_press  (pb_press),
    .pb_release(pb_release),
    .pb_hold   (pb_hold)
  );

  // ---------------- reference model ----------------
  int   cyc = 0;
  logic raw_q[$];
  logic m_sn;
  logic m_clean = 1'b1;
  int   run = 0;
  int   press_cyc = 0;
  bit   press_live = 0;
  logic e_press = 1'b0, e_rel = 1'b0, e_hold = 1'b0;
  int   e_press_total = 0;

  always @(posedge clk) begin
    cyc++;
    e_press = 1'b0;
    e_rel   = 1'b0;
    e_hold  = 1'b0;
    if (rst) begin
      raw_q      = '{1'b1, 1'b1};
      m_clean    = 1'b1;
      run        = 0;
      press_live = 0;
    end else begin
      // the level the debouncer judges is the raw input two samples ago
      m_sn = raw_q.pop_front();
      raw_q.push_back(pb_raw_n);
      if (m_sn != m_clean) run++;
      else run = 0;
      if (run == D) begin
        run = 0;
        if (m_clean) begin
          m_clean = 1'b0; e_press = 1'b1; e_press_total++;
          press_cyc = cyc; press_live = 1;
        end else begin
          m_clean = 1'b1; e_rel = 1'b1; press_live = 0;
        end
      end
      if (press_live && (cyc == press_cyc + H)) e_hold = 1'b1;
    end
  end

  // ---------------- cycle monitor ----------------
  logic prev_press = 1'b0, prev_rel = 1'b0, prev_hold = 1'b0;
  int   dut_press_total = 0;

  always @(negedge clk) begin
    total_cnt++;
    if ({pb_clean_n, pb_press, pb_release, pb_hold} !== {m_clean, e_press, e_rel, e_hold})
      $display("FAIL model_cmp cyc=%0d got clean/press/rel/hold=%b%b%b%b want %b%b%b%b",
               cyc, pb_clean_n, pb_press, pb_release, pb_hold, m_clean, e_press, e_rel, e_hold);
    else pass_cnt++;

    total_cnt++;
    if ((int'(pb_press) + int'(pb_release) + int'(pb_hold) > 1) ||
        (pb_press && prev_press) || (pb_release && prev_rel) || (pb_hold && prev_hold))
      $display("FAIL pulse_excl cyc=%0d got press/rel/hold=%b%b%b prev=%b%b%b want one-hot single-cycle",
               cyc, pb_press, pb_release, pb_hold, prev_press, prev_rel, prev_hold);
    else pass_cnt++;

    if (pb_press === 1'b1) dut_press_total++;
    prev_press = pb_press;
    prev_rel   = pb_release;
    prev_hold  = pb_hold;
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; pb_raw_n = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({pb_clean_n, pb_press, pb_release, pb_hold} !== 4'b1000)
      $display("FAIL reset_vals got %b%b%b%b want 1000", pb_clean_n, pb_press, pb_release, pb_hold);
    else pass_cnt++;
    pb_raw_n = 1'b0;
    repeat (8) @(negedge clk);
    total_cnt++;
    if ({pb_clean_n, pb_press} !== 2'b10)
      $display("FAIL reset_hold_pressed got clean/press=%b%b want 10", pb_clean_n, pb_press);
    else pass_cnt++;
    pb_raw_n = 1'b1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clean_press();
    int press_at, n_press, n_other, rel_at, n_rel;
    press_at = -1; n_press = 0; n_other = 0; rel_at = -1; n_rel = 0;
    pb_raw_n = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (pb_press) begin n_press++; press_at = k; end
      if (pb_release || pb_hold) n_other++;
      if (k == 5) begin
        total_cnt++;
        if (pb_clean_n !== 1'b1) $display("FAIL press_early got clean=%b want 1", pb_clean_n);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (press_at != 6 || n_press != 1)
      $display("FAIL press_latency got at=%0d n=%0d want at=6 n=1", press_at, n_press);
    else pass_cnt++;
    total_cnt++;
    if (pb_clean_n !== 1'b0) $display("FAIL press_level got clean=%b want 0", pb_clean_n);
    else pass_cnt++;
    pb_raw_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (pb_release) begin n_rel++; rel_at = k; end
      if (pb_press || pb_hold) n_other++;
    end
    total_cnt++;
    if (rel_at != 6 || n_rel != 1 || n_other != 0)
      $display("FAIL release_latency got at=%0d n=%0d other=%0d want at=6 n=1 other=0",
               rel_at, n_rel, n_other);
    else pass_cnt++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_bounce();
    int n_pulse;
    bit went_low;
    n_pulse = 0; went_low = 0;
    for (int k = 0; k < 18; k++) begin
      pb_raw_n = (k < 3 || (k >= 4 && k < 7)) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (pb_press || pb_release || pb_hold) n_pulse++;
      if (pb_clean_n !== 1'b1) went_low = 1;
    end
    total_cnt++;
    if (n_pulse != 0 || went_low)
      $display("FAIL bounce_reject got pulses=%0d clean_low=%0d want 0 0", n_pulse, went_low);
    else pass_cnt++;
  endtask

  task automatic test_long_press();
    int press_at, hold_at, n_hold, rel_at;
    press_at = -1; hold_at = -1; n_hold = 0; rel_at = -1;
    pb_raw_n = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (pb_press) press_at = k;
      if (pb_hold) begin n_hold++; hold_at = k; end
    end
    pb_raw_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (pb_release) rel_at = k;
      if (pb_hold) n_hold++;
    end
    total_cnt++;
    if (press_at != 6) $display("FAIL long_press_at got %0d want 6", press_at);
    else pass_cnt++;
    total_cnt++;
    if (hold_at != press_at + H || n_hold != 1)
      $display("FAIL long_hold got at=%0d n=%0d want at=%0d n=1", hold_at, n_hold, press_at + H);
    else pass_cnt++;
    total_cnt++;
    if (rel_at != 6) $display("FAIL long_release_at got %0d want 6", rel_at);
    else pass_cnt++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_release_bounce();
    int press_at, hold_at, n_rel;
    press_at = -1; hold_at = -1; n_rel = 0;
    pb_raw_n = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (pb_press) press_at = k;
      if (pb_hold) hold_at = k;
      if (pb_release) n_rel++;
      if (k == 11) pb_raw_n = 1'b1;
      if (k == 13) pb_raw_n = 1'b0;
    end
    total_cnt++;
    if (n_rel != 0 || pb_clean_n !== 1'b0)
      $display("FAIL rel_bounce_reject got rel=%0d clean=%b want 0 0", n_rel, pb_clean_n);
    else pass_cnt++;
    total_cnt++;
    if (press_at != 6 || hold_at != 16)
      $display("FAIL rel_bounce_hold got press=%0d hold=%0d want 6 16", press_at, hold_at);
    else pass_cnt++;
    pb_raw_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (pb_release) n_rel++;
    end
    total_cnt++;
    if (n_rel != 1) $display("FAIL rel_bounce_final got rel=%0d want 1", n_rel);
    else pass_cnt++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_press();
    int press_at, press_at2, n_pulse_rst, n_hold;
    press_at = -1; press_at2 = -1; n_pulse_rst = 0; n_hold = 0;
    pb_raw_n = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (pb_press) press_at = k;
    end
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (pb_press || pb_release || pb_hold || pb_clean_n !== 1'b1) n_pulse_rst++;
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (pb_press) press_at2 = k;
      if (pb_hold) n_hold++;
    end
    total_cnt++;
    if (press_at != 6 || n_pulse_rst != 0)
      $display("FAIL rst_mid_abort got press=%0d bad_rst_cycles=%0d want 6 0", press_at, n_pulse_rst);
    else pass_cnt++;
    total_cnt++;
    if (press_at2 != 6 || n_hold != 0)
      $display("FAIL rst_mid_repress got at=%0d holds=%0d want 6 0", press_at2, n_hold);
    else pass_cnt++;
    pb_raw_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    int remaining, base_dut, base_model;
    remaining = 0;
    base_dut = dut_press_total;
    base_model = e_press_total;
    for (int i = 0; i < 1500; i++) begin
      if (remaining == 0) begin
        pb_raw_n  = ~pb_raw_n;
        remaining = $urandom_range(1, 24);
      end
      remaining--;
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    total_cnt++;
    if (dut_press_total - base_dut != e_press_total - base_model)
      $display("FAIL random_press_count got %0d want %0d",
               dut_press_total - base_dut, e_press_total - base_model);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_release_bounce();
    test_reset_mid_press();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
